if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID register.
- Decouples IF_stage from ID_stage with a DEPTH-entry instruction queue. Each entry holds an instruction word and its PC.
- Uses a valid/ready handshake on both sides and a synchronous flush for taken jumps/branches.
- Presents a NOP (all zeros) to ID_stage whenever empty, so the decoder always sees a defined word.

Parameters:
- DATA_W, 32, instruction word width.
- PC_W, 32, program-counter width.
- DEPTH, 4, number of queue entries; any integer >= 2 (not required to be a power of 2).
- NOP_WORD, 0, value driven on out_instr when the queue is empty.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; discards all entries (jump/branch redirect).
- in_valid  input  1  IF has an instruction this cycle.
- in_ready  output  1  queue can accept a push this cycle.
- in_instr  input  DATA_W  instruction from IF.
- in_pc  input  PC_W  PC of in_instr.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  ID consumes the head this cycle (low = ID stall).
- out_instr  output  DATA_W  head instruction, or NOP_WORD when empty.
- out_pc  output  PC_W  head PC, or 0 when empty.
- level  output  clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage and pointers:
  - Circular buffer with rd_ptr, wr_ptr in 0..DEPTH-1.
  - A pointer at DEPTH-1 wraps to 0 on increment; no power-of-2 masking is allowed.
- Flags:
  - in_ready = (level < DEPTH). It depends on registered state only and does not look at out_ready.
  - out_valid = (level != 0).
- Transfers:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Per-cycle update, when flush is low:
  - push only: write entry at wr_ptr, wr_ptr++, level++.
  - pop only: rd_ptr++, level--.
  - push and pop together: both pointers advance, level unchanged.
- Read path:
  - out_instr and out_pc are driven combinationally from the entry at rd_ptr, muxed to NOP_WORD / 0 when level == 0.
- Latency:
  - A push into an empty queue appears on the outputs the next cycle.
  - There is no same-cycle bypass from in_* to out_*.
- Full:
  - in_ready = 0, so in_valid is ignored and nothing is overwritten.
  - A pop in the same cycle does not enable a push; in_ready rises the following cycle.
- Empty:
  - out_ready is ignored; rd_ptr and level are unchanged.
- Flush (highest priority):
  - rd_ptr, wr_ptr and level are cleared to 0 at the next edge.
  - A push or pop in the same cycle is discarded.
  - Next cycle: out_valid = 0, out_instr = NOP_WORD, in_ready = 1.
- Reset:
  - Asynchronous and takes effect immediately, including mid-transfer.
  - Values while asserted: rd_ptr = wr_ptr = level = 0, out_valid = 0, in_ready = 1, out_instr = NOP_WORD, out_pc = 0.
  - Storage array is not reset. Its contents are never visible because of the empty mux.
- Stall:
  - out_ready = 0 holds out_instr/out_pc stable for as long as out_valid = 1.
  - Under a stall the queue fills to DEPTH, then in_ready drops.
- Handshake rules:
  - Consumer may hold out_ready high continuously.
  - Producer must hold in_instr/in_pc stable only in the cycle of the push.

Test Plan:
- Reset then idle:
  - Assert rst_n = 0 mid-cycle, release.
  - Required: out_valid = 0, in_ready = 1, level = 0, out_instr = 0x00000000.
- Fill under stall:
  - out_ready = 0; push PCs 0x00, 0x04, 0x08, 0x0C with instrs 0x20080001..0x20080004 (DEPTH = 4).
  - Required: level = 4, in_ready = 0, out_instr = 0x20080001. A fifth push of PC 0x10 is not accepted.
- Drain and wrap:
  - From full, out_ready = 1 with in_valid = 1 continuous, pushing PCs 0x10, 0x14, ...
  - Required: outputs appear in PC order 0x00, 0x04, ..., 0x1C; wr_ptr wraps 3 -> 0 with no loss or duplication.
- Simultaneous push/pop at level 2:
  - Push and pop in the same cycle.
  - Required: level stays 2; the head advances to the next PC in order.
- Flush with concurrent push:
  - level = 3, flush = 1 and in_valid = 1 (PC 0x40) in the same cycle.
  - Required: next cycle level = 0 and out_valid = 0. A subsequent push of PC 0x80 is the head one cycle later.
- Non-power-of-2:
  - DEPTH = 3; push 7 and pop 7 interleaved.
  - Required: order preserved; level never exceeds 3; pointers wrap 2 -> 0.

Source files
------------

// File: rtl/if_id_queue_if.sv
// Handshake bundle for one side of the IF/ID instruction queue:
// valid/ready plus the instruction word and its PC.
interface if_id_queue_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] instr;
  logic [PC_W-1:0]   pc;

  modport master (output valid, output instr, output pc, input  ready);
  modport slave  (input  valid, input  instr, input  pc, output ready);
endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry circular instruction queue between IF and ID with valid/ready
// on both sides, synchronous flush, and a NOP presented whenever empty.
module if_id_queue #(
  parameter int                DATA_W   = 32,
  parameter int                PC_W     = 32,
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] NOP_WORD = '0,
  localparam int               LEVEL_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  if_id_queue_if.slave       in_bus,
  if_id_queue_if.master      out_bus,
  output logic [LEVEL_W-1:0] level
);
  localparam int                 PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(DEPTH - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH);

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem    [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              not_full;
  logic              not_empty;
  logic              push;
  logic              pop;

  // Explicit wrap so non-power-of-2 depths stay inside 0..DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign not_full  = (level < LEVEL_FULL);
  assign not_empty = (level != '0);
  assign push      = in_bus.valid & not_full;
  assign pop       = not_empty & out_bus.ready;

  // in_ready comes from registered occupancy only, never from out_ready.
  assign in_bus.ready  = not_full;
  assign out_bus.valid = not_empty;
  assign out_bus.instr = not_empty ? instr_mem[rd_ptr] : NOP_WORD;
  assign out_bus.pc    = not_empty ? pc_mem[rd_ptr]    : '0;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_mem[wr_ptr] <= in_bus.instr;
      pc_mem[wr_ptr]    <= in_bus.pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: DEPTH=4 and DEPTH=3 instances share one stimulus
// stream and are compared against queue-based reference models.
module tb_if_id_queue;
  localparam int DW = 32;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic iv = 1'b0;
  logic [DW-1:0] ii = '0;
  logic [PW-1:0] ip = '0;
  logic ordy = 1'b0;
  logic [2:0] level4;
  logic [1:0] level3;

  always #5 clk = ~clk;

  if_id_queue_if #(.DATA_W(DW), .PC_W(PW)) in4 ();
  if_id_queue_if #(.DATA_W(DW), .PC_W(PW)) out4 ();
  if_id_queue_if #(.DATA_W(DW), .PC_W(PW)) in3 ();
  if_id_queue_if #(.DATA_W(DW), .PC_W(PW)) out3 ();

  assign in4.valid = iv;
  assign in4.instr = ii;
  assign in4.pc    = ip;
  assign out4.ready = ordy;
  assign in3.valid = iv;
  assign in3.instr = ii;
  assign in3.pc    = ip;
  assign out3.ready = ordy;

  if_id_queue #(.DATA_W(DW), .PC_W(PW), .DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_bus(in4), .out_bus(out4), .level(level4));

  if_id_queue #(.DATA_W(DW), .PC_W(PW), .DEPTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_bus(in3), .out_bus(out3), .level(level3));

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [PW-1:0] pc;
  } ent_t;

  ent_t mq4[$];
  ent_t mq3[$];

  int n_checks = 0;
  int n_err = 0;

  typedef struct {
    logic          iv;
    logic [PW-1:0] pc;
    logic          ordy;
    logic          fl;
    int            lvl;
    logic          v;
    logic          r;
    logic [PW-1:0] epc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [DW-1:0] ins_of(input logic [PW-1:0] pc);
    return 32'h2008_0001 + (pc >> 2);
  endfunction

  function automatic vec_t mk(input logic v_in, input logic [PW-1:0] pc, input logic rd,
                              input logic fl, input int lvl, input logic v,
                              input logic r, input logic [PW-1:0] epc);
    vec_t t;
    t.iv = v_in; t.pc = pc; t.ordy = rd; t.fl = fl;
    t.lvl = lvl; t.v = v; t.r = r; t.epc = epc;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: bounded FIFO, flush empties it, full rejects pushes
  // even when a pop happens in the same cycle.
  task automatic model_step(input logic v, input logic [DW-1:0] i,
                            input logic [PW-1:0] p, input logic r, input logic f);
    bit do_push, do_pop;
    ent_t e;
    e.instr = i;
    e.pc = p;
    if (f) begin
      mq4.delete();
      mq3.delete();
    end else begin
      do_push = v && (mq4.size() < 4);
      do_pop  = r && (mq4.size() > 0);
      if (do_pop) void'(mq4.pop_front());
      if (do_push) mq4.push_back(e);
      do_push = v && (mq3.size() < 3);
      do_pop  = r && (mq3.size() > 0);
      if (do_pop) void'(mq3.pop_front());
      if (do_push) mq3.push_back(e);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".d4.level"}, 64'(level4), 64'(mq4.size()));
    chk({tag, ".d4.out_valid"}, 64'(out4.valid), 64'(mq4.size() != 0));
    chk({tag, ".d4.in_ready"}, 64'(in4.ready), 64'(mq4.size() < 4));
    chk({tag, ".d4.out_instr"}, 64'(out4.instr), (mq4.size() != 0) ? 64'(mq4[0].instr) : 64'h0);
    chk({tag, ".d4.out_pc"}, 64'(out4.pc), (mq4.size() != 0) ? 64'(mq4[0].pc) : 64'h0);
    chk({tag, ".d3.level"}, 64'(level3), 64'(mq3.size()));
    chk({tag, ".d3.out_valid"}, 64'(out3.valid), 64'(mq3.size() != 0));
    chk({tag, ".d3.in_ready"}, 64'(in3.ready), 64'(mq3.size() < 3));
    chk({tag, ".d3.out_instr"}, 64'(out3.instr), (mq3.size() != 0) ? 64'(mq3[0].instr) : 64'h0);
    chk({tag, ".d3.out_pc"}, 64'(out3.pc), (mq3.size() != 0) ? 64'(mq3[0].pc) : 64'h0);
  endtask

  // Inputs change at the negedge, state is sampled at the following negedge.
  task automatic cycle(input string tag, input logic v, input logic [DW-1:0] i,
                       input logic [PW-1:0] p, input logic r, input logic f);
    iv = v; ii = i; ip = p; ordy = r; flush = f;
    @(posedge clk);
    model_step(v, i, p, r, f);
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    int pushed;
    int popped;
    logic [PW-1:0] exp_pc;
    logic [PW-1:0] pc_ctr;
    logic v;
    logic r;
    logic f;
    bit acc;
    bit pp;

    // Reset asserted from time zero, released mid-cycle.
    @(negedge clk);
    chk("rst.out_valid", 64'(out4.valid), 64'h0);
    chk("rst.in_ready", 64'(in4.ready), 64'h1);
    chk("rst.level", 64'(level4), 64'h0);
    chk("rst.out_instr", 64'(out4.instr), 64'h0);
    chk("rst.out_pc", 64'(out4.pc), 64'h0);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check_model("idle");

    // Directed DEPTH=4 table: fill under stall, drain with wrap, push+pop at 2,
    // stall hold, empty pop, flush with concurrent push.
    tbl.push_back(mk(1, 32'h00, 0, 0, 1, 1, 1, 32'h00));
    tbl.push_back(mk(1, 32'h04, 0, 0, 2, 1, 1, 32'h00));
    tbl.push_back(mk(1, 32'h08, 0, 0, 3, 1, 1, 32'h00));
    tbl.push_back(mk(1, 32'h0C, 0, 0, 4, 1, 0, 32'h00));
    tbl.push_back(mk(1, 32'h10, 0, 0, 4, 1, 0, 32'h00));
    tbl.push_back(mk(1, 32'h10, 1, 0, 3, 1, 1, 32'h04));
    tbl.push_back(mk(1, 32'h10, 1, 0, 3, 1, 1, 32'h08));
    tbl.push_back(mk(1, 32'h14, 1, 0, 3, 1, 1, 32'h0C));
    tbl.push_back(mk(1, 32'h18, 1, 0, 3, 1, 1, 32'h10));
    tbl.push_back(mk(1, 32'h1C, 1, 0, 3, 1, 1, 32'h14));
    tbl.push_back(mk(0, 32'h00, 1, 0, 2, 1, 1, 32'h18));
    tbl.push_back(mk(1, 32'h20, 1, 0, 2, 1, 1, 32'h1C));
    tbl.push_back(mk(0, 32'h00, 1, 0, 1, 1, 1, 32'h20));
    tbl.push_back(mk(0, 32'h00, 0, 0, 1, 1, 1, 32'h20));
    tbl.push_back(mk(0, 32'h00, 1, 0, 0, 0, 1, 32'h00));
    tbl.push_back(mk(0, 32'h00, 1, 0, 0, 0, 1, 32'h00));
    tbl.push_back(mk(1, 32'h30, 0, 0, 1, 1, 1, 32'h30));
    tbl.push_back(mk(1, 32'h34, 0, 0, 2, 1, 1, 32'h30));
    tbl.push_back(mk(1, 32'h38, 0, 0, 3, 1, 1, 32'h30));
    tbl.push_back(mk(1, 32'h40, 1, 1, 0, 0, 1, 32'h00));
    tbl.push_back(mk(1, 32'h80, 0, 0, 1, 1, 1, 32'h80));
    tbl.push_back(mk(0, 32'h00, 1, 0, 0, 0, 1, 32'h00));

    for (int k = 0; k < tbl.size(); k++) begin
      cycle($sformatf("vec%0d", k), tbl[k].iv, ins_of(tbl[k].pc), tbl[k].pc,
            tbl[k].ordy, tbl[k].fl);
      chk($sformatf("vec%0d.level", k), 64'(level4), 64'(tbl[k].lvl));
      chk($sformatf("vec%0d.out_valid", k), 64'(out4.valid), 64'(tbl[k].v));
      chk($sformatf("vec%0d.in_ready", k), 64'(in4.ready), 64'(tbl[k].r));
      chk($sformatf("vec%0d.out_pc", k), 64'(out4.pc), 64'(tbl[k].epc));
      chk($sformatf("vec%0d.out_instr", k), 64'(out4.instr),
          tbl[k].v ? 64'(ins_of(tbl[k].epc)) : 64'h0);
    end

    // DEPTH=3: seven pushes and seven pops interleaved, order must hold.
    cycle("np2.flush", 0, '0, '0, 0, 1);
    pushed = 0;
    popped = 0;
    exp_pc = 32'h100;
    for (int k = 0; k < 60 && popped < 7; k++) begin
      v = (pushed < 7) && (k % 3 != 2);
      r = (k % 2 == 1);
      acc = v && (mq3.size() < 3);
      pp = r && (mq3.size() > 0);
      if (pp) begin
        chk("np2.order", 64'(out3.pc), 64'(exp_pc));
        exp_pc = exp_pc + 32'h4;
        popped++;
      end
      cycle("np2", v, ins_of(32'h100 + 4 * pushed), 32'h100 + 4 * pushed, r, 0);
      if (acc) pushed++;
      chk("np2.level_max", 64'(level3 <= 2'd3), 64'h1);
    end
    chk("np2.popped", 64'(popped), 64'd7);

    // Randomised traffic with occasional flushes.
    pc_ctr = 32'h1000;
    for (int k = 0; k < 400; k++) begin
      v = ($urandom_range(3) != 0);
      r = ($urandom_range(2) != 0);
      f = ($urandom_range(31) == 0);
      cycle("rand", v, $urandom, pc_ctr, r, f);
      pc_ctr = pc_ctr + 32'h4;
    end

    // Reset asserted mid-cycle while holding entries must clear immediately.
    cycle("prerst", 1, 32'hDEAD_0001, 32'h2000, 0, 0);
    cycle("prerst", 1, 32'hDEAD_0002, 32'h2004, 0, 0);
    iv = 1'b0;
    ordy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    mq4.delete();
    mq3.delete();
    check_model("midrst");
    @(negedge clk);
    check_model("rsthold");
    #3 rst_n = 1'b1;
    @(negedge clk);
    check_model("postrst");
    cycle("postrst.push", 1, 32'h1234_5678, 32'h3000, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
